// File: rtl/mux_nto1_pipe.sv
// N-way word multiplexer with a registered output and a 2-entry skid buffer on a valid/ready handshake.
// Optional out-of-range beat counter enabled by defining MUX_NTO1_SEL_ERR_CNT_EN.
module mux_nto1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr,
  output logic [15:0]             err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   main_data_r;
  logic               main_err_r;
  logic [WIDTH-1:0]   skid_data_r;
  logic               skid_err_r;
  logic               out_valid_r;
  logic               in_ready_r;

  logic [WIDTH-1:0]   pick_data_s;
  logic               pick_err_s;
  logic               accept_s;

  // Select the addressed word; out-of-range indices yield zero and flag an error.
  always_comb begin
    pick_data_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      pick_data_s = pick_data_s | (in_bus[i*WIDTH +: WIDTH] & {WIDTH{sel == SEL_W'(i)}});
    end
    pick_err_s = !({1'b0, sel} < (SEL_W+1)'(NUM_IN));
  end

  assign accept_s = in_valid && in_ready_r;

  // Skid-buffer state machine; in_ready is a flop so it never depends on out_ready combinationally.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r     <= EMPTY;
      main_data_r <= '0;
      main_err_r  <= 1'b0;
      skid_data_r <= '0;
      skid_err_r  <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            main_data_r <= pick_data_s;
            main_err_r  <= pick_err_s;
            out_valid_r <= 1'b1;
            state_r     <= ONE;
          end
        end
        ONE: begin
          if (accept_s && out_ready) begin
            main_data_r <= pick_data_s;
            main_err_r  <= pick_err_s;
          end else if (accept_s) begin
            skid_data_r <= pick_data_s;
            skid_err_r  <= pick_err_s;
            in_ready_r  <= 1'b0;
            state_r     <= TWO;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= EMPTY;
          end
        end
        TWO: begin
          if (out_ready) begin
            main_data_r <= skid_data_r;
            main_err_r  <= skid_err_r;
            in_ready_r  <= 1'b1;
            state_r     <= ONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= EMPTY;
        end
      endcase
    end
  end

  assign out       = main_data_r;
  assign sel_err   = main_err_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;

`ifdef MUX_NTO1_SEL_ERR_CNT_EN
  logic [15:0] err_cnt_r;

  // Saturating count of accepted out-of-range beats; clear wins over a coincident increment.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      err_cnt_r <= 16'h0000;
    end else if (err_clr) begin
      err_cnt_r <= 16'h0000;
    end else if (accept_s && pick_err_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = err_clr;
  assign err_cnt          = 16'h0000;
`endif

endmodule
